// File: rtl/frame_rdout_sched_pkg.sv
// Shared types, sizing and helpers for the frame readout scheduler.
package frame_rdout_sched_pkg;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;
    localparam int CNT_W      = 4;
    localparam int EVT_W      = 12;
    localparam int NSAMP_W    = 7;
    localparam int ENTRY_W    = EVT_W + NSAMP_W;
    localparam int WD_W       = 16;
    localparam int DROP_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_RETIRE = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [EVT_W-1:0]   evt_num;
        logic [NSAMP_W-1:0] nsamp;
    } evt_entry_t;

    function automatic logic [1:0] vote2(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [NSAMP_W-1:0] last_samp(input logic [NSAMP_W-1:0] n);
        return (n == '0) ? '0 : n - 7'd1;
    endfunction
endpackage

// File: rtl/frame_rdout_sched_fifo.sv
// 8-entry event queue; head is visible on rd_data without a read strobe.
module frame_evt_fifo
    import frame_rdout_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    // A full queue still takes a write when the head leaves on the same edge.
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/frame_rdout_sched.sv
// Queues accepted triggers and presents them one at a time to the frame sequencer.
//   state  | meaning
//   IDLE   | buffer empty to sequencer, pop head when queue non-empty
//   LOAD   | publish popped event, drop L1A_BUF_MT
//   ACTIVE | event presented, wait for LAST_WRD, watchdog running
//   RETIRE | one-cycle guard before the next pop
module frame_rdout_sched
    import frame_rdout_sched_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                L1A_MATCH,
    input  logic [EVT_W-1:0]    L1A_CNT,
    input  logic [NSAMP_W-1:0]  NSAMP,
    input  logic                LAST_WRD,
    input  logic                CLR_STAT,
    output logic                L1A_BUF_MT,
    output logic [NSAMP_W-1:0]  SAMP_MAX,
    output logic [EVT_W-1:0]    EVT_NUM,
    output logic [CNT_W-1:0]    PEND_CNT,
    output logic                OVRFLW,
    output logic [DROP_W-1:0]   DROP_CNT,
    output logic                TMO,
    output logic [1:0]          SCHED_STATE
);
    sched_state_e       state_q [3];
    sched_state_e       state_d, state_v;
    logic               buf_mt_q [3];
    logic               buf_mt_d, buf_mt_v;
    evt_entry_t         head_q, head_d, fifo_rd_data, fifo_wr_data;
    logic [EVT_W-1:0]   evt_num_q, evt_num_d;
    logic [NSAMP_W-1:0] samp_max_q, samp_max_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               tmo_q, tmo_d, ovrflw_q, ovrflw_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic               pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    assign fifo_wr_data = {L1A_CNT, NSAMP};

    frame_evt_fifo u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (L1A_MATCH),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign state_v  = sched_state_e'(vote2(state_q[0], state_q[1], state_q[2]));
    assign buf_mt_v = (buf_mt_q[0] & buf_mt_q[1]) | (buf_mt_q[0] & buf_mt_q[2]) |
                      (buf_mt_q[1] & buf_mt_q[2]);

    always_comb begin
        state_d    = state_v;
        buf_mt_d   = buf_mt_v;
        head_d     = head_q;
        evt_num_d  = evt_num_q;
        samp_max_d = samp_max_q;
        wd_d       = wd_q;
        tmo_d      = tmo_q && !CLR_STAT;
        ovrflw_d   = ovrflw_q && !CLR_STAT;
        drop_cnt_d = CLR_STAT ? '0 : drop_cnt_q;
        pop        = 1'b0;
        case (state_v)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    head_d  = fifo_rd_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                evt_num_d  = head_q.evt_num;
                samp_max_d = last_samp(head_q.nsamp);
                buf_mt_d   = 1'b0;
                wd_d       = '0;
                state_d    = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // Watchdog only flags; the sequencer still owns the retire.
                if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == '1) tmo_d = 1'b1;
                end
                if (LAST_WRD) begin
                    buf_mt_d = 1'b1;
                    state_d  = ST_RETIRE;
                end
            end
            ST_RETIRE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (L1A_MATCH && fifo_full && !pop) begin
            ovrflw_d = 1'b1;
            if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i]  <= ST_IDLE;
                buf_mt_q[i] <= 1'b1;
            end
            head_q     <= '0;
            evt_num_q  <= '0;
            samp_max_q <= '0;
            wd_q       <= '0;
            tmo_q      <= 1'b0;
            ovrflw_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i]  <= state_d;
                buf_mt_q[i] <= buf_mt_d;
            end
            head_q     <= head_d;
            evt_num_q  <= evt_num_d;
            samp_max_q <= samp_max_d;
            wd_q       <= wd_d;
            tmo_q      <= tmo_d;
            ovrflw_q   <= ovrflw_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign L1A_BUF_MT  = buf_mt_v;
    assign SAMP_MAX    = samp_max_q;
    assign EVT_NUM     = evt_num_q;
    assign PEND_CNT    = fifo_count;
    assign OVRFLW      = ovrflw_q;
    assign DROP_CNT    = drop_cnt_q;
    assign TMO         = tmo_q;
    assign SCHED_STATE = state_v;
endmodule

// File: tb/tb_frame_rdout_sched.sv
// Self-checking bench: vector table, directed corner sequences, random run vs. event-level model.
module tb_frame_rdout_sched;
    logic        CLK = 1'b0;
    logic        RST, L1A_MATCH, LAST_WRD, CLR_STAT;
    logic [11:0] L1A_CNT;
    logic [6:0]  NSAMP;
    logic        L1A_BUF_MT, OVRFLW, TMO;
    logic [6:0]  SAMP_MAX;
    logic [11:0] EVT_NUM;
    logic [3:0]  PEND_CNT;
    logic [7:0]  DROP_CNT;
    logic [1:0]  SCHED_STATE;

    int n_checks = 0;
    int n_fail   = 0;
    int pend_peak;

    frame_rdout_sched dut (
        .CLK(CLK), .RST(RST), .L1A_MATCH(L1A_MATCH), .L1A_CNT(L1A_CNT), .NSAMP(NSAMP),
        .LAST_WRD(LAST_WRD), .CLR_STAT(CLR_STAT), .L1A_BUF_MT(L1A_BUF_MT),
        .SAMP_MAX(SAMP_MAX), .EVT_NUM(EVT_NUM), .PEND_CNT(PEND_CNT), .OVRFLW(OVRFLW),
        .DROP_CNT(DROP_CNT), .TMO(TMO), .SCHED_STATE(SCHED_STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        m;
        logic [11:0] c;
        logic [6:0]  n;
        logic        l;
        logic        clr;
        logic        mt;
        logic [11:0] evt;
        logic [6:0]  samp;
        logic [3:0]  pend;
        logic [1:0]  st;
    } vec_t;

    typedef struct {
        logic [11:0] cnt;
        logic [6:0]  ns;
    } ev_t;

    // Event-level reference model
    ev_t         mq[$];
    ev_t         m_cap;
    bit          m_loading, m_present, m_mt, m_ovf, m_tmo;
    int          m_cool, m_wd, m_drop;
    logic [11:0] m_evt;
    logic [6:0]  m_samp;

    task automatic model_reset();
        mq.delete();
        m_loading = 0; m_present = 0; m_mt = 1; m_ovf = 0; m_tmo = 0;
        m_cool = 0; m_wd = 0; m_drop = 0; m_evt = '0; m_samp = '0;
    endtask

    task automatic model_edge(input bit m, input logic [11:0] c, input logic [6:0] n,
                              input bit l, input bit clr);
        bit  idle;
        ev_t e;
        idle = !m_present && !m_loading && (m_cool == 0);
        if (clr) begin m_ovf = 0; m_drop = 0; m_tmo = 0; end
        if (m_cool > 0) m_cool--;
        if (m_loading) begin
            m_evt = m_cap.cnt;
            m_samp = (m_cap.ns == 7'd0) ? 7'd0 : m_cap.ns - 7'd1;
            m_mt = 0; m_present = 1; m_wd = 0; m_loading = 0;
        end else if (m_present) begin
            if (m_wd < 65535) begin
                m_wd++;
                if (m_wd == 65535) m_tmo = 1;
            end
            if (l) begin m_present = 0; m_mt = 1; m_cool = 1; end
        end
        if (idle && mq.size() > 0) begin m_cap = mq.pop_front(); m_loading = 1; end
        if (m) begin
            if (mq.size() < 8) begin e.cnt = c; e.ns = n; mq.push_back(e); end
            else begin m_ovf = 1; if (m_drop < 255) m_drop++; end
        end
    endtask

    function automatic logic [35:0] model_pack();
        logic [1:0] st;
        st = m_loading ? 2'd1 : m_present ? 2'd2 : (m_cool > 0) ? 2'd3 : 2'd0;
        return {m_mt, m_evt, m_samp, 4'(mq.size()), m_ovf, 8'(m_drop), m_tmo, st};
    endfunction

    function automatic logic [35:0] dut_pack();
        return {L1A_BUF_MT, EVT_NUM, SAMP_MAX, PEND_CNT, OVRFLW, DROP_CNT, TMO, SCHED_STATE};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        if (int'(PEND_CNT) > pend_peak) pend_peak = int'(PEND_CNT);
    endtask

    task automatic drive(input logic m, input logic [11:0] c, input logic [6:0] n,
                         input logic l, input logic clr);
        L1A_MATCH = m; L1A_CNT = c; NSAMP = n; LAST_WRD = l; CLR_STAT = clr;
    endtask

    task automatic do_reset();
        drive(0, '0, '0, 0, 0);
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic wait_present(input string name, output int waited);
        waited = 0;
        while (L1A_BUF_MT !== 1'b0 && waited < 20) begin
            step();
            waited++;
        end
        check(name, L1A_BUF_MT, 1'b0);
    endtask

    vec_t tv[15];
    int   waited;
    int   last_pct;
    bit   rm, rl, rc;
    logic [11:0] rcnt;
    logic [6:0]  rns;

    initial begin
        tv[0]  = '{1'b1, 12'h123, 7'd8,   1'b0, 1'b0, 1'b1, 12'h000, 7'd0,   4'd1, 2'd0};
        tv[1]  = '{1'b0, 12'h000, 7'd0,   1'b0, 1'b0, 1'b1, 12'h000, 7'd0,   4'd0, 2'd1};
        tv[2]  = '{1'b0, 12'h000, 7'd0,   1'b0, 1'b0, 1'b0, 12'h123, 7'd7,   4'd0, 2'd2};
        tv[3]  = '{1'b0, 12'h000, 7'd0,   1'b1, 1'b0, 1'b1, 12'h123, 7'd7,   4'd0, 2'd3};
        tv[4]  = '{1'b1, 12'h0AB, 7'd0,   1'b0, 1'b0, 1'b1, 12'h123, 7'd7,   4'd1, 2'd0};
        tv[5]  = '{1'b0, 12'h000, 7'd0,   1'b0, 1'b0, 1'b1, 12'h123, 7'd7,   4'd0, 2'd1};
        tv[6]  = '{1'b0, 12'h000, 7'd0,   1'b0, 1'b0, 1'b0, 12'h0AB, 7'd0,   4'd0, 2'd2};
        tv[7]  = '{1'b1, 12'h7FF, 7'd127, 1'b0, 1'b0, 1'b0, 12'h0AB, 7'd0,   4'd1, 2'd2};
        tv[8]  = '{1'b0, 12'h000, 7'd0,   1'b1, 1'b0, 1'b1, 12'h0AB, 7'd0,   4'd1, 2'd3};
        tv[9]  = '{1'b0, 12'h000, 7'd0,   1'b1, 1'b0, 1'b1, 12'h0AB, 7'd0,   4'd1, 2'd0};
        tv[10] = '{1'b0, 12'h000, 7'd0,   1'b1, 1'b0, 1'b1, 12'h0AB, 7'd0,   4'd0, 2'd1};
        tv[11] = '{1'b0, 12'h000, 7'd0,   1'b1, 1'b0, 1'b0, 12'h7FF, 7'd126, 4'd0, 2'd2};
        tv[12] = '{1'b0, 12'h000, 7'd0,   1'b0, 1'b1, 1'b0, 12'h7FF, 7'd126, 4'd0, 2'd2};
        tv[13] = '{1'b0, 12'h000, 7'd0,   1'b1, 1'b0, 1'b1, 12'h7FF, 7'd126, 4'd0, 2'd3};
        tv[14] = '{1'b0, 12'h000, 7'd0,   1'b0, 1'b0, 1'b1, 12'h7FF, 7'd126, 4'd0, 2'd0};

        pend_peak = 0;
        RST = 1'b1;
        drive(0, '0, '0, 0, 0);
        do_reset();
        check("reset_state", dut_pack(), {1'b1, 35'd0});

        // Vector table: single event, NSAMP=0 and 127, LAST_WRD ignored outside ACTIVE
        for (int i = 0; i < 15; i++) begin
            drive(tv[i].m, tv[i].c, tv[i].n, tv[i].l, tv[i].clr);
            step();
            check($sformatf("vec%0d", i), {L1A_BUF_MT, EVT_NUM, SAMP_MAX, PEND_CNT, SCHED_STATE},
                  {tv[i].mt, tv[i].evt, tv[i].samp, tv[i].pend, tv[i].st});
        end
        drive(0, '0, '0, 0, 0);

        // Three back-to-back triggers presented in order with the retire gap
        do_reset();
        pend_peak = 0;
        for (int k = 1; k <= 3; k++) begin
            drive(1, 12'(k), 7'd4, 0, 0);
            step();
        end
        drive(0, '0, '0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            wait_present($sformatf("order_present%0d", k), waited);
            check($sformatf("order_evt%0d", k), EVT_NUM, 64'(k));
            if (k > 1) check($sformatf("order_gap%0d", k), 64'(waited >= 3), 64'd1);
            LAST_WRD = 1'b1;
            step();
            LAST_WRD = 1'b0;
            check($sformatf("order_retire%0d", k), L1A_BUF_MT, 1'b1);
        end
        check("order_peak", 64'(pend_peak), 64'd2);

        // Overflow: ten triggers, one presented, eight queued, one dropped
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 12'(16 + i), 7'd4, 0, 0);
            step();
        end
        drive(0, '0, '0, 0, 0);
        check("ovf_state", {L1A_BUF_MT, EVT_NUM, PEND_CNT, OVRFLW, DROP_CNT},
              {1'b0, 12'h010, 4'd8, 1'b1, 8'd1});
        CLR_STAT = 1'b1; step(); CLR_STAT = 1'b0;
        check("ovf_clear", {PEND_CNT, OVRFLW, DROP_CNT}, {4'd8, 1'b0, 8'd0});
        drive(1, 12'hFFF, 7'd1, 0, 1); step();
        check("clr_vs_drop", {OVRFLW, DROP_CNT}, {1'b1, 8'd1});
        drive(1, 12'hFFF, 7'd1, 0, 0); step();
        check("drop_two", DROP_CNT, 8'd2);
        repeat (260) step();
        check("drop_saturate", {OVRFLW, DROP_CNT}, {1'b1, 8'd255});
        drive(0, '0, '0, 0, 1); step(); CLR_STAT = 1'b0;
        check("sat_clear", {OVRFLW, DROP_CNT, PEND_CNT}, {1'b0, 8'd0, 4'd8});

        // Full queue: trigger lands on the pop edge and is kept
        LAST_WRD = 1'b1; step(); LAST_WRD = 1'b0;
        step();
        check("full_idle", SCHED_STATE, 2'd0);
        drive(1, 12'h0EE, 7'd2, 0, 0); step();
        drive(0, '0, '0, 0, 0);
        check("full_pushpop", {PEND_CNT, OVRFLW, DROP_CNT, SCHED_STATE},
              {4'd8, 1'b0, 8'd0, 2'd1});
        step();
        check("full_next_evt", {L1A_BUF_MT, EVT_NUM, SAMP_MAX}, {1'b0, 12'h011, 7'd3});

        // Watchdog
        do_reset();
        drive(1, 12'h039, 7'd16, 0, 0); step();
        drive(0, '0, '0, 0, 0);
        wait_present("wd_present", waited);
        repeat (65534) step();
        check("wd_before", TMO, 1'b0);
        step();
        check("wd_trip", {TMO, L1A_BUF_MT}, {1'b1, 1'b0});
        repeat (10) step();
        check("wd_hold", {TMO, L1A_BUF_MT, SCHED_STATE}, {1'b1, 1'b0, 2'd2});
        LAST_WRD = 1'b1; step(); LAST_WRD = 1'b0;
        check("wd_retire", {L1A_BUF_MT, SCHED_STATE}, {1'b1, 2'd3});
        CLR_STAT = 1'b1; step(); CLR_STAT = 1'b0;
        check("wd_clear", {TMO, SCHED_STATE}, {1'b0, 2'd0});

        // Reset mid-event with four queued
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 12'(32 + i), 7'd5, 0, 0);
            step();
        end
        drive(0, '0, '0, 0, 0);
        step();
        check("rst_pre", {L1A_BUF_MT, PEND_CNT}, {1'b0, 4'd4});
        #2 RST = 1'b1;
        #1 check("rst_async", dut_pack(), {1'b1, 35'd0});
        step();
        step();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rst_quiet%0d", i), {L1A_BUF_MT, PEND_CNT, SCHED_STATE},
                  {1'b1, 4'd0, 2'd0});
        end
        drive(1, 12'h055, 7'd3, 0, 0); step();
        drive(0, '0, '0, 0, 0);
        step();
        step();
        check("rst_after_evt", {L1A_BUF_MT, EVT_NUM, SAMP_MAX}, {1'b0, 12'h055, 7'd2});

        // Random traffic against the event-level model
        do_reset();
        model_reset();
        last_pct = 20;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       last_pct = 0;
                    1:       last_pct = 5;
                    default: last_pct = 40;
                endcase
            end
            rm   = ($urandom_range(0, 99) < 35);
            rcnt = 12'($urandom);
            rns  = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom);
            rl   = ($urandom_range(0, 99) < last_pct);
            rc   = ($urandom_range(0, 99) < 2);
            drive(rm, rcnt, rns, rl, rc);
            model_edge(rm, rcnt, rns, rl, rc);
            step();
            check($sformatf("rand%0d", cyc), dut_pack(), model_pack());
        end
        drive(0, '0, '0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_rdout_sched.md
FRAME_RDOUT_SCHED -- requirements
Module: frame_rdout_sched

Interface
REQ-001 SHALL have ports: CLK input 1 (sole clock, all logic rising-edge); RST input 1 (asynchronous, active-high reset).
REQ-002 SHALL have L1A_MATCH input 1: one-cycle pulse; the event is accepted for readout.
REQ-003 SHALL have L1A_CNT input 12: event number, sampled with L1A_MATCH.
REQ-004 SHALL have NSAMP input 7: configured samples per event, sampled with L1A_MATCH.
REQ-005 SHALL have LAST_WRD input 1: one-cycle pulse from the frame sequencer marking the end of an event.
REQ-006 SHALL have CLR_STAT input 1: synchronous clear of sticky status.
REQ-007 SHALL have L1A_BUF_MT output 1: high means no event is presented to the frame sequencer.
REQ-008 SHALL have SAMP_MAX output 7: last sample index of the presented event.
REQ-009 SHALL have EVT_NUM output 12: event number of the presented event.
REQ-010 SHALL have PEND_CNT output 4: queued events, 0..8, excluding the presented event.
REQ-011 SHALL have OVRFLW output 1: sticky flag, set when an L1A_MATCH is dropped.
REQ-012 SHALL have DROP_CNT output 8: dropped-event count, saturating at 255.
REQ-013 SHALL have TMO output 1: sticky watchdog flag.
REQ-014 SHALL have SCHED_STATE output 2: voted/current state encoding, for debug.

Function
REQ-015 SHALL queue accepted events as {L1A_CNT, NSAMP} entries in an 8-deep FIFO, in first-in first-out order.
REQ-016 SHALL push the entry on the cycle L1A_MATCH=1 when the FIFO is not full.
REQ-017 SHALL, when the FIFO is full and L1A_MATCH=1, drop the event, set OVRFLW, and increment DROP_CNT.
REQ-018 SHALL have FSM states IDLE=0, LOAD=1, ACTIVE=2, RETIRE=3.
REQ-019 SHALL transition IDLE->LOAD when the FIFO is non-empty, popping the head on the same edge.
REQ-020 SHALL, on the LOAD edge, register EVT_NUM, register SAMP_MAX = NSAMP-1 (NSAMP=0 gives SAMP_MAX=0), set L1A_BUF_MT<=0, and go to ACTIVE.
REQ-021 SHALL hold EVT_NUM and SAMP_MAX stable throughout ACTIVE.
REQ-022 SHALL, in ACTIVE with LAST_WRD=1, set L1A_BUF_MT<=1 on that edge and go to RETIRE, so that the sequencer sees the buffer empty in its Idle cycle.
REQ-023 SHALL go RETIRE->IDLE unconditionally, giving a minimum 3-cycle gap between LAST_WRD and the next L1A_BUF_MT fall.
REQ-024 SHALL ignore LAST_WRD in IDLE, LOAD and RETIRE.
REQ-025 SHALL, on a simultaneous push and pop, perform both operations, leaving PEND_CNT unchanged; a push is not dropped when the pop frees the slot on the same edge.
REQ-026 SHALL run a 16-bit watchdog in ACTIVE: cleared on entry, incremented each cycle, and setting TMO when it reaches 0xFFFF.
REQ-027 SHALL hold the watchdog at 0xFFFF after TMO is set, taking no forced retire action.
REQ-028 SHALL, when CLR_STAT=1, clear OVRFLW, DROP_CNT and TMO on that edge; a drop on the same cycle wins, setting OVRFLW=1 and DROP_CNT=1.
REQ-029 SHALL make PEND_CNT a registered output equal to the FIFO occupancy.

Reset
REQ-030 SHALL, with RST=1, asynchronously force: state IDLE, FIFO empty, L1A_BUF_MT=1, SAMP_MAX=0, EVT_NUM=0, PEND_CNT=0, OVRFLW=0, DROP_CNT=0, TMO=0, watchdog=0.
REQ-031 SHALL, on reset mid-event, discard queued and presented events with no residual pulses; after release the block starts in IDLE.

Structure
REQ-032 SHALL place in a shared package: state encodings, FIFO depth (8), entry width (19), watchdog width (16), and DROP_CNT width (8).
REQ-033 SHALL implement the queue as sub-module frame_evt_fifo: 8x19 synchronous FIFO with full, empty and count outputs, on the same CLK/RST.
REQ-034 SHALL triplicate the FSM state and the L1A_BUF_MT register with majority voting; the FIFO is not triplicated.

Verification
REQ-035 SHALL verify: single L1A_MATCH, L1A_CNT=0x123, NSAMP=8 -> two edges later L1A_BUF_MT=0, EVT_NUM=0x123, SAMP_MAX=7; LAST_WRD -> L1A_BUF_MT=1 on the next edge.
REQ-036 SHALL verify: 3 back-to-back L1A_MATCH (CNT 1,2,3) -> PEND_CNT peaks at 2; events are presented in order 1,2,3, each L1A_BUF_MT fall at least 3 cycles after the prior LAST_WRD.
REQ-037 SHALL verify: 10 L1A_MATCH with no LAST_WRD -> 1 presented event, PEND_CNT=8, OVRFLW=1, DROP_CNT=1; CLR_STAT -> OVRFLW=0, DROP_CNT=0.
REQ-038 SHALL verify: FIFO full, L1A_MATCH in the same cycle as the pop (IDLE->LOAD) -> no drop, PEND_CNT stays 8.
REQ-039 SHALL verify: ACTIVE with no LAST_WRD for 65535 cycles -> TMO=1 and L1A_BUF_MT stays 0; later LAST_WRD -> normal retire.
REQ-040 SHALL verify: RST pulse during ACTIVE with PEND_CNT=4 -> immediately L1A_BUF_MT=1, PEND_CNT=0, all flags 0; the following L1A_MATCH is presented normally.
